// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared APB types for the APB-to-register bridges.
//   apb_h2d_t            : host-to-device request (psel, penable, pwrite,
//                          paddr, pwdata, pstrb)
//   apb_d2h_t            : device-to-host response (pready, prdata, pslverr)
//   apb_adapter_state_e  : state encoding of the wait-state adapter
//   ApbAdapterTimeoutDefault : default ack timeout in cycles
// -----------------------------------------------------------------------------
package apb_pkg;

    localparam int unsigned ApbAw = 32;
    localparam int unsigned ApbDw = 32;
    localparam int unsigned ApbBw = ApbDw / 8;

    localparam int unsigned ApbAdapterTimeoutDefault = 16;

    typedef struct packed {
        logic             psel;
        logic             penable;
        logic             pwrite;
        logic [ApbAw-1:0] paddr;
        logic [ApbDw-1:0] pwdata;
        logic [ApbBw-1:0] pstrb;
    } apb_h2d_t;

    typedef struct packed {
        logic             pready;
        logic [ApbDw-1:0] prdata;
        logic             pslverr;
    } apb_d2h_t;

    typedef enum logic [1:0] {
        AdIdle   = 2'd0,
        AdAccess = 2'd1,
        AdResp   = 2'd2
    } apb_adapter_state_e;

endpackage

// File: rtl/reg_timeout_counter.sv
// -----------------------------------------------------------------------------
// reg_timeout_counter
// Counts cycles while enabled and flags the cycle in which the Limit-th
// enabled cycle is reached. Limit = 0 disables expiry entirely.
//   clk_i     : clock
//   rst_i     : synchronous reset, active-high
//   clear_i   : return count to zero (dominates enable)
//   enable_i  : count this cycle
//   expired_o : high during the Limit-th consecutive enabled cycle
// -----------------------------------------------------------------------------
module reg_timeout_counter #(
    parameter int unsigned Limit = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    generate
        if (Limit == 0) begin : g_disabled
            logic unused_inputs;
            assign unused_inputs = clk_i ^ rst_i ^ clear_i ^ enable_i;
            assign expired_o     = 1'b0;
        end else begin : g_count
            localparam int unsigned CntW = $clog2(Limit + 1);

            logic [CntW-1:0] cnt_q, cnt_d;

            // The count equals the number of enabled cycles already completed,
            // so the Limit-th cycle is the one where the count is Limit-1.
            assign expired_o = enable_i && (cnt_q == CntW'(Limit - 1));

            always_comb begin
                cnt_d = cnt_q;
                if (clear_i) begin
                    cnt_d = '0;
                end else if (enable_i && !expired_o) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/apb_adapter_reg_ws.sv
// -----------------------------------------------------------------------------
// apb_adapter_reg_ws
// APB slave to level-request register interface, with wait states, an ack
// timeout and an address-range check that answer with PSLVERR.
//   clk_i / rst_i : clock, synchronous active-high reset
//   apb_i / apb_o : APB request / response
//   re_o / we_o   : read / write request, level, held until ack or timeout
//   addr_o        : registered word-aligned address
//   wdata_o       : registered write data
//   wstrb_o       : registered byte strobes (zero for reads)
//   rdata_i       : read data, sampled with ack_i
//   error_i       : target error, sampled with ack_i
//   ack_i         : target completion (may arrive in the first request cycle)
//   timeout_o     : one-cycle pulse when the ack timeout fires
// -----------------------------------------------------------------------------
module apb_adapter_reg_ws
    import apb_pkg::*;
#(
    parameter int unsigned RegAw         = 8,
    parameter int unsigned RegDw         = 32,
    parameter int unsigned RegBw         = RegDw / 8,
    parameter int unsigned AddrLimit     = 2 ** RegAw,
    parameter int unsigned TimeoutCycles = ApbAdapterTimeoutDefault
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  apb_h2d_t         apb_i,
    output apb_d2h_t         apb_o,
    output logic             re_o,
    output logic             we_o,
    output logic [RegAw-1:0] addr_o,
    output logic [RegDw-1:0] wdata_o,
    output logic [RegBw-1:0] wstrb_o,
    input  logic [RegDw-1:0] rdata_i,
    input  logic             error_i,
    input  logic             ack_i,
    output logic             timeout_o
);

    apb_adapter_state_e state_q, state_d;
    logic               pwrite_q, pwrite_d;
    logic [RegAw-1:0]   addr_q, addr_d;
    logic [RegDw-1:0]   wdata_q, wdata_d;
    logic [RegBw-1:0]   wstrb_q, wstrb_d;
    logic [RegDw-1:0]   prdata_q, prdata_d;
    logic               pslverr_q, pslverr_d;
    logic               timeout_q, timeout_d;

    logic setup;
    logic addr_err;
    logic expired;
    logic in_access;

    // Byte-lane bits of paddr are dropped by word alignment.
    logic unused_paddr;
    assign unused_paddr = ^apb_i.paddr[1:0];

    assign setup     = apb_i.psel && !apb_i.penable;
    assign in_access = (state_q == AdAccess);

    // Bits above the decoded window are checked separately so an alias of an
    // in-range address can never slip past the limit compare.
    assign addr_err = ({1'b0, apb_i.paddr} >= (ApbAw + 1)'(AddrLimit))
                   || (|apb_i.paddr[ApbAw-1:RegAw]);

    reg_timeout_counter #(
        .Limit (TimeoutCycles)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (!in_access),
        .enable_i  (in_access),
        .expired_o (expired)
    );

    always_comb begin
        state_d   = state_q;
        pwrite_d  = pwrite_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
        timeout_d = 1'b0;

        unique case (state_q)
            AdIdle: begin
                if (setup) begin
                    if (addr_err) begin
                        // Out-of-window: answer straight away, never touch
                        // the register side.
                        state_d   = AdResp;
                        pslverr_d = 1'b1;
                        prdata_d  = '0;
                    end else begin
                        state_d  = AdAccess;
                        pwrite_d = apb_i.pwrite;
                        addr_d   = {apb_i.paddr[RegAw-1:2], 2'b00};
                        wdata_d  = apb_i.pwdata[RegDw-1:0];
                        wstrb_d  = apb_i.pwrite ? apb_i.pstrb[RegBw-1:0] : '0;
                    end
                end
            end

            AdAccess: begin
                // Ack is tested first so an ack in the expiry cycle wins.
                // If the master has already abandoned the transfer (psel low)
                // the result is dropped and we go straight back to Idle.
                if (ack_i) begin
                    prdata_d  = pwrite_q ? '0 : rdata_i;
                    pslverr_d = error_i;
                    state_d   = apb_i.psel ? AdResp : AdIdle;
                end else if (expired) begin
                    prdata_d  = '0;
                    pslverr_d = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = apb_i.psel ? AdResp : AdIdle;
                end
            end

            AdResp: begin
                state_d   = AdIdle;
                prdata_d  = '0;
                pslverr_d = 1'b0;
            end

            default: begin
                state_d = AdIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= AdIdle;
            pwrite_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pwrite_q  <= pwrite_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            timeout_q <= timeout_d;
        end
    end

    // Requests follow the state register directly, so a reset drops them on
    // the same edge that returns the FSM to Idle.
    assign re_o      = in_access && !pwrite_q;
    assign we_o      = in_access && pwrite_q;
    assign addr_o    = addr_q;
    assign wdata_o   = wdata_q;
    assign wstrb_o   = wstrb_q;
    assign timeout_o = timeout_q;

    // Response fields are forced to zero outside the pready cycle, which also
    // hides any result left behind by an abandoned transfer.
    always_comb begin
        apb_o         = '0;
        apb_o.pready  = (state_q == AdResp);
        apb_o.prdata  = apb_o.pready ? ApbDw'(prdata_q) : '0;
        apb_o.pslverr = apb_o.pready && pslverr_q;
    end

endmodule

// File: tb/tb_apb_adapter_reg_ws.sv
// -----------------------------------------------------------------------------
// tb_apb_adapter_reg_ws
// Directed bench for apb_adapter_reg_ws (AddrLimit = 0x40, timeout 16).
// -----------------------------------------------------------------------------
module tb_apb_adapter_reg_ws;
    import apb_pkg::*;

    localparam int unsigned RegAw         = 8;
    localparam int unsigned RegDw         = 32;
    localparam int unsigned RegBw         = 4;
    localparam int unsigned AddrLimit     = 32'h40;
    localparam int unsigned TimeoutCycles = 16;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    apb_h2d_t         apb_i;
    apb_d2h_t         apb_o;
    logic             re_o, we_o;
    logic [RegAw-1:0] addr_o;
    logic [RegDw-1:0] wdata_o;
    logic [RegBw-1:0] wstrb_o;
    logic [RegDw-1:0] rdata_i;
    logic             error_i;
    logic             ack_i;
    logic             timeout_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    apb_adapter_reg_ws #(
        .RegAw         (RegAw),
        .RegDw         (RegDw),
        .RegBw         (RegBw),
        .AddrLimit     (AddrLimit),
        .TimeoutCycles (TimeoutCycles)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .apb_i     (apb_i),
        .apb_o     (apb_o),
        .re_o      (re_o),
        .we_o      (we_o),
        .addr_o    (addr_o),
        .wdata_o   (wdata_o),
        .wstrb_o   (wstrb_o),
        .rdata_i   (rdata_i),
        .error_i   (error_i),
        .ack_i     (ack_i),
        .timeout_o (timeout_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apb_idle();
        apb_i.psel    = 1'b0;
        apb_i.penable = 1'b0;
        ack_i         = 1'b0;
    endtask

    // One APB transfer. ack_dly is the 0-based request cycle in which ack_i
    // is raised (-1 = never). Returns with the bench sitting in the pready
    // cycle and the bus inputs idled, so calls may run back-to-back.
    task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdat, input logic [3:0] strb,
                        input int ack_dly, input logic [31:0] rdat, input logic err,
                        input int exp_req, input logic exp_err,
                        input logic [31:0] exp_rd, input logic exp_to);
        int   req    = 0;
        int   lat    = 0;
        logic saw_to = 1'b0;
        logic done   = 1'b0;
        logic [31:0] exp_addr;
        exp_addr = {24'h0, addr[7:2], 2'b00};

        step();
        chk({tag, ":idle_pready"}, 32'(apb_o.pready), 32'h0);
        chk({tag, ":idle_prdata"}, apb_o.prdata, 32'h0);
        chk({tag, ":idle_req"}, 32'(re_o | we_o), 32'h0);
        chk({tag, ":idle_timeout"}, 32'(timeout_o), 32'h0);

        apb_i.psel    = 1'b1;
        apb_i.penable = 1'b0;
        apb_i.pwrite  = wr;
        apb_i.paddr   = addr;
        apb_i.pwdata  = wdat;
        apb_i.pstrb   = strb;
        rdata_i       = rdat;
        error_i       = err;
        ack_i         = 1'b0;
        step();
        apb_i.penable = 1'b1;

        for (int c = 0; c < 40 && !done; c++) begin
            saw_to = saw_to | timeout_o;
            if (apb_o.pready) begin
                done = 1'b1;
                lat  = c;
            end else begin
                chk({tag, ":wait_prdata"}, apb_o.prdata, 32'h0);
                chk({tag, ":wait_pslverr"}, 32'(apb_o.pslverr), 32'h0);
                if (re_o || we_o) begin
                    req++;
                    chk({tag, ":we"}, 32'(we_o), 32'(wr));
                    chk({tag, ":re"}, 32'(re_o), 32'(!wr));
                    chk({tag, ":addr"}, 32'(addr_o), exp_addr);
                    chk({tag, ":wstrb"}, 32'(wstrb_o), wr ? 32'(strb) : 32'h0);
                    if (wr) chk({tag, ":wdata"}, wdata_o, wdat);
                end
                ack_i = (ack_dly >= 0) && (req == ack_dly + 1);
                step();
            end
        end

        chk({tag, ":done"}, 32'(done), 32'h1);
        chk({tag, ":latency"}, 32'(lat), 32'(exp_req));
        chk({tag, ":req_cycles"}, 32'(req), 32'(exp_req));
        chk({tag, ":pslverr"}, 32'(apb_o.pslverr), 32'(exp_err));
        chk({tag, ":prdata"}, apb_o.prdata, exp_rd);
        chk({tag, ":timeout"}, 32'(saw_to), 32'(exp_to));
        $display("xfer %-10s wr=%0d addr=0x%02h req_cycles=%0d prdata=0x%08h pslverr=%0d timeout=%0d",
                 tag, wr, addr, req, apb_o.prdata, apb_o.pslverr, saw_to);
        apb_idle();
    endtask

    initial begin
        apb_i   = '0;
        rdata_i = '0;
        error_i = 1'b0;
        ack_i   = 1'b0;
        rst_i   = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst:re", 32'(re_o), 32'h0);
        chk("rst:we", 32'(we_o), 32'h0);
        chk("rst:pready", 32'(apb_o.pready), 32'h0);
        chk("rst:pslverr", 32'(apb_o.pslverr), 32'h0);
        chk("rst:prdata", apb_o.prdata, 32'h0);
        chk("rst:addr", 32'(addr_o), 32'h0);
        chk("rst:wdata", wdata_o, 32'h0);
        chk("rst:wstrb", 32'(wstrb_o), 32'h0);
        chk("rst:timeout", 32'(timeout_o), 32'h0);
        rst_i = 1'b0;

        // Minimum write: ack in first request cycle, pready one cycle later.
        xfer("wr_min", 1'b1, 32'h14, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0,
             1, 1'b0, 32'h0, 1'b0);
        // Read with five wait cycles before ack: request held six cycles.
        xfer("rd_wait5", 1'b0, 32'h08, 32'h0, 4'h0, 5, 32'h12345678, 1'b0,
             6, 1'b0, 32'h12345678, 1'b0);
        // No ack: request dropped after 16 cycles, timeout error.
        xfer("rd_tmo", 1'b0, 32'h0C, 32'h0, 4'h0, -1, 32'hFFFFFFFF, 1'b0,
             16, 1'b1, 32'h0, 1'b1);
        // Late ack after the timeout must be ignored.
        ack_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("late_ack:pready", 32'(apb_o.pready), 32'h0);
            chk("late_ack:req", 32'(re_o | we_o), 32'h0);
            chk("late_ack:timeout", 32'(timeout_o), 32'h0);
        end
        ack_i = 1'b0;
        // Decode errors: never reach the register side.
        xfer("wr_oor44", 1'b1, 32'h44, 32'h11111111, 4'hF, 0, 32'h0, 1'b0,
             0, 1'b1, 32'h0, 1'b0);
        xfer("rd_lim40", 1'b0, 32'h40, 32'h0, 4'h0, 0, 32'hAAAAAAAA, 1'b0,
             0, 1'b1, 32'h0, 1'b0);
        xfer("rd_hi100", 1'b0, 32'h100, 32'h0, 4'h0, 0, 32'hAAAAAAAA, 1'b0,
             0, 1'b1, 32'h0, 1'b0);
        // Target error on read, then a back-to-back normal write at the top word.
        xfer("rd_err", 1'b0, 32'h10, 32'h0, 4'h0, 2, 32'hCAFEF00D, 1'b1,
             3, 1'b1, 32'hCAFEF00D, 1'b0);
        xfer("wr_b2b", 1'b1, 32'h3F, 32'h0BADCAFE, 4'h5, 1, 32'h99999999, 1'b0,
             2, 1'b0, 32'h0, 1'b0);
        // Ack in the expiry cycle wins over the timeout.
        xfer("rd_ack16", 1'b0, 32'h18, 32'h0, 4'h0, 15, 32'h55AA55AA, 1'b0,
             16, 1'b0, 32'h55AA55AA, 1'b0);

        // psel dropped during Access: request completes, no pready.
        step();
        apb_i.psel    = 1'b1;
        apb_i.penable = 1'b0;
        apb_i.pwrite  = 1'b0;
        apb_i.paddr   = 32'h20;
        rdata_i       = 32'h77777777;
        error_i       = 1'b0;
        step();
        chk("abort:re_t1", 32'(re_o), 32'h1);
        apb_idle();
        step();
        chk("abort:re_t2", 32'(re_o), 32'h1);
        chk("abort:pready_t2", 32'(apb_o.pready), 32'h0);
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        chk("abort:re_t3", 32'(re_o), 32'h0);
        chk("abort:pready_t3", 32'(apb_o.pready), 32'h0);
        step();
        chk("abort:pready_t4", 32'(apb_o.pready), 32'h0);
        chk("abort:prdata_t4", apb_o.prdata, 32'h0);
        $display("xfer %-10s psel dropped mid-request, response discarded", "abort");

        // Reset during Access with re_o high.
        apb_i.psel    = 1'b1;
        apb_i.penable = 1'b0;
        apb_i.pwrite  = 1'b0;
        apb_i.paddr   = 32'h24;
        step();
        apb_i.penable = 1'b1;
        chk("rst_mid:re_t1", 32'(re_o), 32'h1);
        step();
        chk("rst_mid:re_t2", 32'(re_o), 32'h1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        apb_idle();
        chk("rst_mid:re", 32'(re_o), 32'h0);
        chk("rst_mid:pready", 32'(apb_o.pready), 32'h0);
        $display("xfer %-10s reset during request", "rst_mid");
        xfer("rd_post", 1'b0, 32'h24, 32'h0, 4'h0, 1, 32'h0BADF00D, 1'b0,
             2, 1'b0, 32'h0BADF00D, 1'b0);

        step();
        chk("end:pready", 32'(apb_o.pready), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
